// File: rtl/cache_fill_fsm.sv
// D-cache miss handler: fetches an 8-word block from main memory, streams it into the data array, then writes the tag.
// Requests issue back-to-back regardless of memory latency; responses are written in arrival order.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_data,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [15:0]       cache_data,
  output logic              write_data_array,
  output logic              write_tag_array
);

  localparam logic [3:0] NWORDS    = 4'(BLOCK_WORDS);
  localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] miss_q;
  logic [3:0]        req_cnt;
  logic [3:0]        resp_cnt;
  logic [ADDR_W-1:0] req_off;
  logic [ADDR_W-1:0] resp_off;

  // Counters hold word indices; shifting left by one converts to a byte offset.
  assign req_off  = {{(ADDR_W-5){1'b0}}, req_cnt,  1'b0};
  assign resp_off = {{(ADDR_W-5){1'b0}}, resp_cnt, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base     <= '0;
      miss_q   <= '0;
      req_cnt  <= '0;
      resp_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base     <= {miss_address[ADDR_W-1:4], 4'b0};
            miss_q   <= miss_address;
            req_cnt  <= '0;
            resp_cnt <= '0;
          end
        end
        FILL: begin
          if (req_cnt < NWORDS) req_cnt <= req_cnt + 4'd1;
          if (mem_data_valid)   resp_cnt <= resp_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt        = state;
    fsm_busy         = 1'b0;
    mem_enable       = 1'b0;
    mem_address      = '0;
    cache_addr       = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_data       = mem_data;
    case (state)
      IDLE: begin
        // Pass-through keeps hit reads undisturbed while no fill is active.
        cache_addr = miss_address;
        if (miss_detected) state_nxt = FILL;
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (req_cnt < NWORDS) begin
          mem_enable  = 1'b1;
          mem_address = base + req_off;
        end
        cache_addr = base;
        if (mem_data_valid) begin
          write_data_array = 1'b1;
          cache_addr       = base + resp_off;
          if (resp_cnt == LAST_WORD) state_nxt = TAG;
        end
      end
      TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        cache_addr      = miss_q;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: a 3-stage delay-line memory (or hand-driven returns) and per-cycle logging.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_enable;
  logic [15:0] mem_address;
  logic        mem_data_valid;
  logic [15:0] mem_data;
  logic [15:0] cache_addr;
  logic [15:0] cache_data;
  logic        write_data_array;
  logic        write_tag_array;

  cache_fill_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .fsm_busy(fsm_busy), .mem_enable(mem_enable), .mem_address(mem_address),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .cache_addr(cache_addr), .cache_data(cache_data),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc;
  int busy_cnt;
  bit busy_hist [0:63];
  bit          v_d [3];
  logic [15:0] a_d [3];
  logic [15:0] req_a[$];
  int          req_c[$];
  logic [15:0] wr_a[$];
  logic [15:0] wr_d[$];
  int          wr_c[$];
  logic [15:0] tag_a[$];
  int          tag_c[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    req_a.delete(); req_c.delete();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    tag_a.delete(); tag_c.delete();
    busy_cnt = 0;
    for (int i = 0; i < 64; i++) busy_hist[i] = 1'b0;
    cyc = 0;
  endtask

  // One clock cycle; memory returns a request three cycles after it was issued.
  task automatic run_cycle(input bit manual, input bit m_vld, input logic [15:0] m_dat);
    @(posedge clk);
    #1;
    cyc++;
    if (manual) begin
      mem_data_valid = m_vld;
      mem_data       = m_dat;
    end else begin
      mem_data_valid = v_d[2];
      mem_data       = {13'd0, a_d[2][3:1]};
    end
    v_d[2] = v_d[1]; a_d[2] = a_d[1];
    v_d[1] = v_d[0]; a_d[1] = a_d[0];
    v_d[0] = mem_enable; a_d[0] = mem_address;
    #1;
    if (mem_enable) begin req_a.push_back(mem_address); req_c.push_back(cyc); end
    if (write_data_array) begin
      wr_a.push_back(cache_addr); wr_d.push_back(cache_data); wr_c.push_back(cyc);
    end
    if (write_tag_array) begin tag_a.push_back(cache_addr); tag_c.push_back(cyc); end
    if (fsm_busy) busy_cnt++;
    if (cyc < 64) busy_hist[cyc] = fsm_busy;
  endtask

  task automatic begin_fill(input logic [15:0] addr, input bit keep);
    clear_log();
    miss_address  = addr;
    miss_detected = 1'b1;
    run_cycle(1'b0, 1'b0, 16'h0);
    if (!keep) miss_detected = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin v_d[i] = 1'b0; a_d[i] = 16'h0; end
    clear_log();
    rst_n          = 1'b0;
    miss_detected  = 1'b0;
    miss_address   = 16'h0000;
    mem_data_valid = 1'b1;
    mem_data       = 16'hBEEF;

    // Reset with returns asserted
    #12;
    chk("rst_busy", fsm_busy, 0);
    chk("rst_mem_en", mem_enable, 0);
    chk("rst_mem_addr", mem_address, 16'h0);
    chk("rst_wr_data", write_data_array, 0);
    chk("rst_wr_tag", write_tag_array, 0);
    chk("rst_cache_addr", cache_addr, 16'h0);
    chk("rst_cache_data", cache_data, 16'hBEEF);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 16'h7777);
    chk("idle_no_writes", wr_a.size(), 0);
    chk("idle_no_busy", busy_cnt, 0);
    chk("idle_no_req", req_a.size(), 0);
    miss_address = 16'hABCD;
    #1;
    chk("idle_passthru", cache_addr, 16'hABCD);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 16'h0);

    // Basic fill at 0x1234
    begin_fill(16'h1234, 1'b0);
    while (cyc < 16) run_cycle(1'b0, 1'b0, 16'h0);
    chk("b_req_n", req_a.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("b_req_addr", req_a[i], 16'h1230 + 16'(2 * i));
      chk("b_req_cyc", req_c[i], i + 1);
    end
    chk("b_wr_n", wr_a.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("b_wr_addr", wr_a[i], 16'h1230 + 16'(2 * i));
      chk("b_wr_data", wr_d[i], 16'(i));
      chk("b_wr_cyc", wr_c[i], i + 4);
    end
    chk("b_tag_n", tag_a.size(), 1);
    chk("b_tag_addr", tag_a[0], 16'h1234);
    chk("b_tag_cyc", tag_c[0], 12);
    chk("b_busy_cnt", busy_cnt, 12);
    chk("b_busy_c12", busy_hist[12], 1);
    chk("b_busy_c13", busy_hist[13], 0);

    // Irregular returns: valid on even cycles only
    begin_fill(16'h0F0E, 1'b0);
    for (int c = 2; c <= 20; c++) begin
      run_cycle(1'b1, (c % 2 == 0) && (c <= 16), 16'h0100 + 16'(c / 2 - 1));
      if (c == 3) chk("g_gap_addr", cache_addr, 16'h0F00);
    end
    chk("g_wr_n", wr_a.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("g_wr_addr", wr_a[i], 16'h0F00 + 16'(2 * i));
      chk("g_wr_data", wr_d[i], 16'h0100 + 16'(i));
    end
    chk("g_tag_n", tag_a.size(), 1);
    chk("g_tag_cyc", tag_c[0], 17);
    chk("g_tag_addr", tag_a[0], 16'h0F0E);
    chk("g_busy_cnt", busy_cnt, 17);
    mem_data_valid = 1'b0;

    // miss_address changes mid-fill while miss_detected stays high
    begin_fill(16'h1234, 1'b1);
    while (cyc < 5) run_cycle(1'b0, 1'b0, 16'h0);
    miss_address = 16'h5432;
    while (cyc < 14) run_cycle(1'b0, 1'b0, 16'h0);
    miss_detected = 1'b0;
    while (cyc < 28) run_cycle(1'b0, 1'b0, 16'h0);
    chk("m_wr_last1", wr_a[7], 16'h123E);
    chk("m_tag1_addr", tag_a[0], 16'h1234);
    chk("m_tag1_cyc", tag_c[0], 12);
    chk("m_busy_c13", busy_hist[13], 0);
    chk("m_busy_c14", busy_hist[14], 1);
    chk("m_req9_addr", req_a[8], 16'h5430);
    chk("m_req9_cyc", req_c[8], 14);
    chk("m_wr9_addr", wr_a[8], 16'h5430);
    chk("m_tag2_addr", tag_a[1], 16'h5432);
    chk("m_tag2_cyc", tag_c[1], 25);
    chk("m_wr_n", wr_a.size(), 16);

    // Reset after the third data write
    begin_fill(16'h2468, 1'b0);
    while (cyc < 6) run_cycle(1'b0, 1'b0, 16'h0);
    chk("r_wr_before", wr_a.size(), 3);
    miss_address = 16'h0000;
    rst_n = 1'b0;
    #1;
    chk("r_busy", fsm_busy, 0);
    chk("r_mem_en", mem_enable, 0);
    chk("r_vld_seen", mem_data_valid, 1);
    chk("r_wr_data", write_data_array, 0);
    chk("r_wr_tag", write_tag_array, 0);
    chk("r_cache_addr", cache_addr, 16'h0);
    run_cycle(1'b0, 1'b0, 16'h0);
    rst_n = 1'b1;
    while (cyc < 16) run_cycle(1'b0, 1'b0, 16'h0);
    chk("r_wr_after", wr_a.size(), 3);
    chk("r_tag_n", tag_a.size(), 0);
    chk("r_busy_cnt", busy_cnt, 6);
    chk("r_req_n", req_a.size(), 6);

    // Back-to-back misses
    begin_fill(16'h1A34, 1'b0);
    while (cyc < 13) run_cycle(1'b0, 1'b0, 16'h0);
    chk("bb_busy_c13", busy_hist[13], 0);
    miss_address  = 16'h1234;
    miss_detected = 1'b1;
    run_cycle(1'b0, 1'b0, 16'h0);
    miss_detected = 1'b0;
    while (cyc < 28) run_cycle(1'b0, 1'b0, 16'h0);
    chk("bb_wr_n", wr_a.size(), 16);
    chk("bb_wr0", wr_a[0], 16'h1A30);
    chk("bb_wr7", wr_a[7], 16'h1A3E);
    chk("bb_wr8", wr_a[8], 16'h1230);
    chk("bb_wr15", wr_a[15], 16'h123E);
    chk("bb_tag_n", tag_a.size(), 2);
    chk("bb_tag1", tag_a[0], 16'h1A34);
    chk("bb_tag2", tag_a[1], 16'h1234);
    chk("bb_tag2_cyc", tag_c[1], 25);
    chk("bb_busy_cnt", busy_cnt, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
